seq_divider: RTL and testbench

Multi-cycle restoring integer divider for the processor's M-extension execute stage, implementing DIV, DIVU, REM and REMU semantics. It is the subtractive counterpart of the ripple-carry adder datapath: one conditional subtract-and-shift step per clock. It accepts one operation on a start pulse, holds busy while iterating, and returns quotient and remainder with a one-cycle done pulse. RISC-V divide-by-zero and signed-overflow rules are applied without iterating.

---
 rtl/seq_divider.sv | 152 +++++++++++++++
 tb/tb_seq_divider.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider (DIV/DIVU/REM/REMU), one subtract-and-shift step per clock.
// Optional macro SEQ_DIVIDER_SIGNED_EN enables two's-complement operation via is_signed.
module seq_divider #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         is_signed,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg;
    logic [N:0]      r_reg;
    logic [N-1:0]    q_reg;
    logic [N-1:0]    d_reg;
    logic            done_reg;
    logic [N-1:0]    quo_reg;
    logic [N-1:0]    rem_reg;

    logic            div_zero;
    logic            special;
    logic [N-1:0]    a_mag;
    logic [N-1:0]    b_mag;
    logic [N:0]      r_shift;
    logic [N:0]      r_diff;
    logic [N-1:0]    q_fixed;
    logic [N-1:0]    r_fixed;
    logic            unused_bits;

    assign div_zero = (divisor == '0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic q_neg_reg;
    logic r_neg_reg;
    logic overflow;

    assign overflow = is_signed && (dividend == {1'b1, {(N-1){1'b0}}}) && (divisor == '1);
    assign a_mag    = (is_signed && dividend[N-1]) ? -dividend : dividend;
    assign b_mag    = (is_signed && divisor[N-1])  ? -divisor  : divisor;
    assign special  = div_zero || overflow;
    assign q_fixed  = q_neg_reg ? -q_reg : q_reg;
    assign r_fixed  = r_neg_reg ? -r_reg[N-1:0] : r_reg[N-1:0];
    // The partial remainder never exceeds the divisor, so its top bit stays clear.
    assign unused_bits = r_reg[N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_neg_reg <= 1'b0;
            r_neg_reg <= 1'b0;
        end else if (state_reg == IDLE && start) begin
            q_neg_reg <= is_signed && (dividend[N-1] ^ divisor[N-1]);
            r_neg_reg <= is_signed && dividend[N-1];
        end
    end
`else
    assign a_mag       = dividend;
    assign b_mag       = divisor;
    assign special     = div_zero;
    assign q_fixed     = q_reg;
    assign r_fixed     = r_reg[N-1:0];
    assign unused_bits = ^{r_reg[N], is_signed};
`endif

    assign r_shift = {r_reg[N-1:0], q_reg[N-1]};
    assign r_diff  = r_shift - {1'b0, d_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = special ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt_reg == CW'(N - 1)) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg  <= '0;
            r_reg    <= '0;
            q_reg    <= '0;
            d_reg    <= '0;
            quo_reg  <= '0;
            rem_reg  <= '0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= (state_reg == DONE);
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        cnt_reg <= '0;
                        r_reg   <= '0;
                        q_reg   <= a_mag;
                        d_reg   <= b_mag;
                        // Special cases publish their results here and bypass CALC/FIX.
                        if (div_zero) begin
                            quo_reg <= '1;
                            rem_reg <= dividend;
                        end else if (special) begin
                            quo_reg <= dividend;
                            rem_reg <= '0;
                        end
                    end
                end
                CALC: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    r_reg   <= r_diff[N] ? r_shift : r_diff;
                    q_reg   <= {q_reg[N-2:0], ~r_diff[N]};
                end
                FIX: begin
                    quo_reg <= q_fixed;
                    rem_reg <= r_fixed;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_reg == CALC) || (state_reg == FIX);
    assign done      = done_reg;
    assign quotient  = quo_reg;
    assign remainder = rem_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider: results, latency, busy span, start-ignore and reset abort.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int errors = 0;
    int checks = 0;
    int lat;
    int bcnt;
    int dcnt;

    seq_divider #(.N(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // Launch one operation and wait (bounded) for done; latency counts edges after the start edge.
    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic sg,
                       output int latency, output int busy_cycles);
        bit found;
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        is_signed = sg;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
        busy_cycles = busy ? 1 : 0;
        latency     = 0;
        found       = 1'b0;
        while (!found && latency < 100) begin
            @(posedge clk);
            #1;
            latency++;
            if (busy) busy_cycles++;
            if (done) found = 1'b1;
        end
        if (!found) latency = -1;
        $display("op a=0x%08h b=0x%08h signed=%0d -> q=0x%08h r=0x%08h latency=%0d busy=%0d",
                 a, b, sg, quotient, remainder, latency, busy_cycles);
    endtask

    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sg,
                      input logic [31:0] eq, input logic [31:0] er, input int elat, input int ebusy);
        int l;
        int bc;
        run(a, b, sg, l, bc);
        check({tag, "_q"}, quotient, eq);
        check({tag, "_r"}, remainder, er);
        check({tag, "_lat"}, l, elat);
        check({tag, "_busy"}, bc, ebusy);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #12;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_q", quotient, 32'd0);
        check("rst_r", remainder, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        op("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 34, 33);
        op("divzero", 32'h12345678, 32'd0, 1'b0, 32'hFFFFFFFF, 32'h12345678, 1, 0);
        op("zero_dividend", 32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 34, 33);
        op("ovf_unsigned", 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0, 32'h80000000, 34, 33);
`ifdef SEQ_DIVIDER_SIGNED_EN
        op("s_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 34, 33);
        op("s_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 34, 33);
        op("s_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1, 0);
        op("s_divzero", 32'hFFFFFFF9, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF9, 1, 0);
`else
        op("ign_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 32'h7FFFFFFC, 32'd1, 34, 33);
        op("ign_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1, 32'd0, 32'd7, 34, 33);
        op("ign_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0, 32'h80000000, 34, 33);
`endif

        // A second start while busy must be neither queued nor disturb the running divide.
        @(negedge clk);
        dividend = 32'd1000; divisor = 32'd3; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        dividend = 32'd5; divisor = 32'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dcnt = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
        end
        $display("busy-start: q=%0d r=%0d done_pulses=%0d", quotient, remainder, dcnt);
        check("ignore_q", quotient, 32'd333);
        check("ignore_r", remainder, 32'd1);
        check("ignore_done_count", dcnt, 32'd1);

        // Reset mid-operation aborts at once and nothing completes afterwards.
        @(negedge clk);
        dividend = 32'hFFFFFFFF; divisor = 32'd1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_q", quotient, 32'd0);
        check("abort_r", remainder, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        repeat (45) begin
            @(posedge clk);
            #1;
            if (done || busy) dcnt++;
        end
        $display("post-reset idle: activity_cycles=%0d", dcnt);
        check("abort_quiet", dcnt, 32'd0);
        op("max_div1", 32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 34, 33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
